// File: rtl/axis_rr_pkt_arbiter_if.sv
// if_axi_stream: one valid/ready stream beat with packet framing.
//   val/rdy : handshake, a beat moves when both are high
//   sop/eop : first / last beat of a packet
//   err     : error flag carried with the beat
//   dat     : DAT_BYTS bytes of payload
//   ctl     : sideband control word
//   mod     : valid-byte count modifier on the eop beat
// source/master drive the beat and sample rdy; sink/slave the reverse.
`timescale 1ns/1ps
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
);
  localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [DAT_BYTS*8-1:0] dat;
  logic [CTL_BITS-1:0]   ctl;
  logic [MOD_BITS-1:0]   mod;

  modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport sink   (input val, sop, eop, err, dat, ctl, mod, output rdy);
  modport master (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport slave  (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/axis_rr_pkt_arbiter.sv
// axis_rr_pkt_arbiter: packet-aware round-robin arbiter, N_IN streams onto one.
// A source keeps the grant from its first accepted beat until its eop beat is
// accepted, so packets never interleave. Output is a one-deep registered slice.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset (release synchronised internally)
//   i_axi   : requester streams, rdy driven here
//   o_axi   : arbitrated output stream
//   o_grant : source index of the beat currently on o_axi
//   o_busy  : a multi-beat packet holds the lock
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no packet open; round-robin pick among requesters
// LOCKED | packet from lock_id open; only lock_id is served until eop
`timescale 1ns/1ps
module axis_rr_pkt_arbiter #(
  parameter int N_IN     = 4,
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8,
  parameter int ID_BITS  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  if_axi_stream.sink          i_axi [N_IN],
  if_axi_stream.source        o_axi,
  output logic [ID_BITS-1:0]  o_grant,
  output logic                o_busy
);
  localparam int DAT_BITS = DAT_BYTS * 8;
  localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;
  localparam int IW       = ID_BITS + 1;
  localparam logic [IW-1:0]      N_IN_W  = IW'(N_IN);
  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(N_IN - 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t state_q, state_d;

  // Two-flop release synchroniser; rdy stays low until it completes.
  logic [1:0] rst_sync_q;
  logic       run;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run = rst_sync_q[1];

  // Flatten the interface array so it can be indexed by a run-time id.
  logic [N_IN-1:0]     in_val, in_sop, in_eop, in_err, in_rdy;
  logic [DAT_BITS-1:0] in_dat [N_IN];
  logic [CTL_BITS-1:0] in_ctl [N_IN];
  logic [MOD_BITS-1:0] in_mod [N_IN];

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    assign in_val[g]    = i_axi[g].val;
    assign in_sop[g]    = i_axi[g].sop;
    assign in_eop[g]    = i_axi[g].eop;
    assign in_err[g]    = i_axi[g].err;
    assign in_dat[g]    = i_axi[g].dat;
    assign in_ctl[g]    = i_axi[g].ctl;
    assign in_mod[g]    = i_axi[g].mod;
    assign i_axi[g].rdy = in_rdy[g];
  end

  logic [ID_BITS-1:0]  rr_ptr_q, lock_id_q, sel, acc_id, next_ptr;
  logic                sel_vld, out_free, acc, acc_eop;

  logic                val_q, sop_q, eop_q, err_q;
  logic [DAT_BITS-1:0] dat_q;
  logic [CTL_BITS-1:0] ctl_q;
  logic [MOD_BITS-1:0] mod_q;
  logic [ID_BITS-1:0]  grant_q;

  // First requester at or after rr_ptr, wrapping. Walking the offsets from
  // high to low lets the smallest offset win.
  always_comb begin : rr_select
    logic [IW-1:0] idx;
    idx     = '0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + IW'(k);
      if (idx >= N_IN_W) idx = idx - N_IN_W;
      if (in_val[idx[ID_BITS-1:0]]) begin
        sel     = idx[ID_BITS-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  assign out_free = ~val_q | o_axi.rdy;
  assign acc_id   = (state_q == ST_LOCKED) ? lock_id_q : sel;
  assign acc      = |(in_val & in_rdy);
  assign acc_eop  = in_eop[acc_id];
  assign next_ptr = (acc_id == LAST_ID) ? '0 : acc_id + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (acc && !acc_eop) state_d = ST_LOCKED;
      ST_LOCKED: if (acc && acc_eop)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_rdy = '0;
    o_busy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run && sel_vld) in_rdy[sel] = out_free;
      end
      ST_LOCKED: begin
        if (run) in_rdy[lock_id_q] = out_free;
        o_busy = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
    end else if (acc) begin
      if (state_q == ST_IDLE) lock_id_q <= sel;
      if (acc_eop)            rr_ptr_q  <= next_ptr;
    end
  end

  // Output slice: load on an accepted beat, drop val when the slot drains
  // with nothing new, hold everything while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      val_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      ctl_q   <= '0;
      mod_q   <= '0;
      grant_q <= '0;
    end else if (out_free) begin
      val_q <= acc;
      if (acc) begin
        sop_q   <= in_sop[acc_id];
        eop_q   <= in_eop[acc_id];
        err_q   <= in_err[acc_id];
        dat_q   <= in_dat[acc_id];
        ctl_q   <= in_ctl[acc_id];
        mod_q   <= in_mod[acc_id];
        grant_q <= acc_id;
      end
    end
  end

  assign o_axi.val = val_q;
  assign o_axi.sop = sop_q;
  assign o_axi.eop = eop_q;
  assign o_axi.err = err_q;
  assign o_axi.dat = dat_q;
  assign o_axi.ctl = ctl_q;
  assign o_axi.mod = mod_q;
  assign o_grant   = grant_q;
endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
`timescale 1ns/1ps
module tb_axis_rr_pkt_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] tb_val, tb_sop, tb_eop, tb_err, dut_rdy;
  logic [63:0]  tb_dat [N];
  logic [7:0]   tb_ctl [N];
  logic [2:0]   tb_mod [N];
  logic         out_rdy;
  logic [1:0]   dut_grant;
  logic         dut_busy;

  if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) in_if [N] ();
  if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) out_if ();

  for (genvar g = 0; g < N; g++) begin : g_src
    assign in_if[g].val = tb_val[g];
    assign in_if[g].sop = tb_sop[g];
    assign in_if[g].eop = tb_eop[g];
    assign in_if[g].err = tb_err[g];
    assign in_if[g].dat = tb_dat[g];
    assign in_if[g].ctl = tb_ctl[g];
    assign in_if[g].mod = tb_mod[g];
    assign dut_rdy[g]   = in_if[g].rdy;
  end
  assign out_if.rdy = out_rdy;

  axis_rr_pkt_arbiter #(.N_IN(N), .DAT_BYTS(8), .CTL_BITS(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_axi   (in_if),
    .o_axi   (out_if),
    .o_grant (dut_grant),
    .o_busy  (dut_busy)
  );

  typedef struct {
    logic [1:0]  g;
    logic [63:0] dat;
    logic [7:0]  ctl;
    logic [2:0]  mod;
    logic        sop, eop, err;
  } beat_t;

  int n_tests = 0;
  int n_fail  = 0;

  // source stimulus state
  int s_mode [N];   // 0 off, 1 always valid, 2 random valid
  int s_lenfix [N]; // 0 = random length 1..4
  int s_modfix [N]; // -1 = random mod
  int s_left [N];   // packets still to send, including the open one
  int s_beat [N];
  int s_len [N];
  int s_pkt [N];
  int s_modv [N];
  int rdy_mode;     // 0 always, 1 random, 2 pattern 1,0,0
  int cyc = 0;

  // reference model: spec-level arbitration state plus an output queue
  beat_t oq[$];
  int    grant_log[$];
  bit    m_locked;
  int    m_lock, m_rr, m_sync;
  int    last_eop_mod;
  bit    val_hi_chk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_pkt(input int s);
    s_len[s]  = (s_lenfix[s] > 0) ? s_lenfix[s] : int'($urandom_range(1, 4));
    s_modv[s] = (s_modfix[s] >= 0) ? s_modfix[s] : int'($urandom_range(0, 7));
  endtask

  task automatic cfg(input int s, input int mode, input int lenfix, input int left, input int modfix);
    s_mode[s]   = mode;
    s_lenfix[s] = lenfix;
    s_left[s]   = left;
    s_modfix[s] = modfix;
    s_beat[s]   = 0;
    new_pkt(s);
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      tb_val[s] = (s_left[s] > 0) &&
                  (s_mode[s] == 1 || (s_mode[s] == 2 && $urandom_range(0, 9) < 6));
      tb_sop[s] = (s_beat[s] == 0);
      tb_eop[s] = (s_beat[s] == s_len[s] - 1);
      tb_dat[s] = {8'(s), 16'(s_pkt[s]), 8'(s_beat[s]), 32'($urandom)};
      tb_ctl[s] = 8'(s_pkt[s] * 3 + s + s_beat[s]);
      tb_mod[s] = tb_eop[s] ? 3'(s_modv[s]) : 3'd0;
      tb_err[s] = ((s_pkt[s] + s_beat[s]) % 5 == 2);
    end
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = ($urandom_range(0, 3) != 0);
      default: out_rdy = (cyc % 3 == 0);
    endcase
  endtask

  // One clock: drive, check at the falling edge, advance the model.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    bit           ofree;
    int           sel;
    beat_t        b;
    drive();
    @(negedge clk);
    exp_rdy = '0;
    sel     = -1;
    ofree   = (oq.size() == 0) || out_rdy;
    if (rst_n && m_sync == 0) begin
      if (m_locked) exp_rdy[2'(m_lock)] = ofree;
      else begin
        for (int k = 0; k < N; k++)
          if (sel < 0 && tb_val[2'((m_rr + k) % N)]) sel = (m_rr + k) % N;
        if (sel >= 0) exp_rdy[2'(sel)] = ofree;
      end
    end
    chk("rdy", 64'(dut_rdy), 64'(exp_rdy));
    chk("busy", 64'(dut_busy), 64'(m_locked));
    chk("o_val", 64'(out_if.val), 64'(oq.size() > 0));
    if (val_hi_chk) chk("val_hi", 64'(out_if.val), 64'd1);
    if (oq.size() > 0) begin
      chk("o_grant", 64'(dut_grant), 64'(oq[0].g));
      chk("o_dat", out_if.dat, oq[0].dat);
      chk("o_ctl", 64'(out_if.ctl), 64'(oq[0].ctl));
      chk("o_mod", 64'(out_if.mod), 64'(oq[0].mod));
      chk("o_flags", 64'({out_if.sop, out_if.eop, out_if.err}),
          64'({oq[0].sop, oq[0].eop, oq[0].err}));
      if (out_rdy) begin
        if (oq[0].eop) last_eop_mod = int'(oq[0].mod);
        void'(oq.pop_front());
      end
    end
    for (int s = 0; s < N; s++) begin
      if (tb_val[s] && exp_rdy[s]) begin
        b.g = 2'(s); b.dat = tb_dat[s]; b.ctl = tb_ctl[s]; b.mod = tb_mod[s];
        b.sop = tb_sop[s]; b.eop = tb_eop[s]; b.err = tb_err[s];
        oq.push_back(b);
        if (!m_locked) grant_log.push_back(s);
        if (tb_eop[s]) begin
          m_locked = 1'b0;
          m_rr     = (s + 1) % N;
          s_beat[s] = 0;
          s_pkt[s]++;
          s_left[s]--;
          new_pkt(s);
        end else begin
          m_locked = 1'b1;
          m_lock   = s;
          s_beat[s]++;
        end
      end
    end
    cyc++;
    @(posedge clk);
    if (rst_n && m_sync > 0) m_sync--;
    #1;
  endtask

  // Run until every source is out of packets and the output is empty.
  // With trim set, sources finish only the packet they have open.
  task automatic drain(input bit trim);
    int pending;
    if (trim)
      for (int s = 0; s < N; s++) begin
        s_left[s] = (s_beat[s] > 0) ? 1 : 0;
        if (s_left[s] > 0) s_mode[s] = 1;
      end
    pending = 1;
    for (int t = 0; t < 400 && pending != 0; t++) begin
      cycle();
      pending = oq.size();
      for (int s = 0; s < N; s++) pending += s_left[s];
    end
    chk("drain_done", 64'(pending), 64'd0);
  endtask

  task automatic model_reset();
    oq.delete();
    m_locked = 1'b0;
    m_lock   = 0;
    m_rr     = 0;
    m_sync   = 2;
    for (int s = 0; s < N; s++) s_beat[s] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    rdy_mode = 0;
    val_hi_chk = 1'b0;
    last_eop_mod = -1;
    for (int s = 0; s < N; s++) begin
      s_pkt[s] = 0;
      cfg(s, 1, 3, 1000, -1);
    end
    model_reset();

    // reset held with every source requesting
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b1;

    // fairness, 3-beat packets, continuous output
    for (int i = 0; i < 3; i++) cycle();
    val_hi_chk = 1'b1;
    for (int i = 0; i < 37; i++) cycle();
    val_hi_chk = 1'b0;
    drain(1'b1);
    chk("fair_cnt", 64'(grant_log.size() >= 12), 64'd1);
    foreach (grant_log[k]) chk("fair_order", 64'(grant_log[k]), 64'(k % N));

    // single-beat packets from sources 1 and 3
    grant_log.delete();
    cfg(1, 1, 1, 10, -1);
    cfg(3, 1, 1, 10, -1);
    drain(1'b0);
    n = grant_log.size();
    chk("sb_cnt", 64'(n), 64'd20);
    if (n >= 2) chk("sb_alt0", 64'(grant_log[0] != grant_log[1]), 64'd1);
    for (int k = 2; k < n; k++) chk("sb_alt", 64'(grant_log[k]), 64'(grant_log[k-2]));

    // backpressure on a 4-beat packet from source 2
    grant_log.delete();
    rdy_mode = 2;
    cfg(2, 1, 4, 1, 5);
    drain(1'b0);
    rdy_mode = 0;
    chk("bp_mod", 64'(last_eop_mod), 64'd5);
    chk("bp_grant", 64'(grant_log.size() == 1 && grant_log[0] == 2), 64'd1);

    // lock held across a valid gap while source 1 waits
    grant_log.delete();
    cfg(0, 1, 2, 1, -1);
    cfg(1, 1, 1, 1, -1);
    for (int t = 0; t < 20 && s_beat[0] == 0; t++) cycle();
    chk("gap_start", 64'(s_beat[0]), 64'd1);
    s_mode[0] = 0;
    for (int i = 0; i < 3; i++) cycle();
    s_mode[0] = 1;
    drain(1'b0);
    chk("gap_cnt", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() >= 2) begin
      chk("gap_g0", 64'(grant_log[0]), 64'd0);
      chk("gap_g1", 64'(grant_log[1]), 64'd1);
    end

    // asynchronous reset in the middle of a 4-beat packet
    cfg(0, 1, 4, 1, -1);
    for (int t = 0; t < 20 && s_beat[0] < 2; t++) cycle();
    chk("ar_beats", 64'(s_beat[0]), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_oval", 64'(out_if.val), 64'd0);
    chk("ar_rdy", 64'(dut_rdy), 64'd0);
    chk("ar_busy", 64'(dut_busy), 64'd0);
    model_reset();
    grant_log.delete();
    for (int i = 0; i < 2; i++) cycle();
    rst_n = 1'b1;
    for (int s = 0; s < N; s++) cfg(s, 1, 2, 1, -1);
    drain(1'b0);
    chk("ar_cnt", 64'(grant_log.size()), 64'd4);
    foreach (grant_log[k]) chk("ar_order", 64'(grant_log[k]), 64'(k));

    // random valid, random lengths, random output backpressure
    rdy_mode = 1;
    for (int s = 0; s < N; s++) cfg(s, 2, 0, 1000, -1);
    for (int i = 0; i < 1500; i++) cycle();
    rdy_mode = 0;
    drain(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_rr_pkt_arbiter.md
Name: axis_rr_pkt_arbiter

Overview:
- Packet-aware round-robin arbiter sharing one if_axi_stream sink between N_IN if_axi_stream sources.
- Sits in front of shared consumers (e.g. a single multiplier core or host DMA path) fed by several requesters.
- Grant is held from a packet's first accepted beat until its eop beat is accepted, so packets never interleave.
- Output is a registered slice; the source index of the current packet is reported alongside the data.

Parameters:
N_IN, 4, number of input streams (2..16)
DAT_BYTS, 8, data bytes per beat on all streams
CTL_BITS, 8, ctl width on all streams
ID_BITS, $clog2(N_IN) (min 1), width of the grant index

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous assert, active-low
i_axi  if_axi_stream.sink [N_IN]  interface array  requester streams (rdy driven by this block)
o_axi  if_axi_stream.source  interface  arbitrated output stream
o_grant  output  ID_BITS  index of the source owning o_axi's current beat (valid when o_axi.val)
o_busy  output  1  high while a multi-beat packet is locked (LOCKED state)

Behaviour:
- Reset (i_rst_n low, async): state IDLE; rr_ptr=0; o_axi.val/sop/eop/err=0, o_axi.dat/ctl/mod=0; o_grant=0; o_busy=0; all i_axi[i].rdy=0. Release is synchronised internally (two flops) before the state machine leaves reset.
- Output slot: out_free = ~o_axi.val | o_axi.rdy. A beat is accepted from source s when i_axi[s].val & i_axi[s].rdy. An accepted beat is registered into o_axi the next cycle with dat/ctl/mod/sop/eop/err copied unchanged and o_grant=s.
- When out_free and nothing is accepted, o_axi.val goes to 0 on the next edge. o_axi holds every field stable while val & ~rdy.
- Round-robin select: sel = first i with i_axi[i].val, searching i = rr_ptr, rr_ptr+1, ... modulo N_IN (wraps past N_IN-1 to 0).
- States:
  - IDLE: i_axi[sel].rdy = out_free, all others 0; combinational, zero bubble. If the accepted beat has eop=0, go to LOCKED with lock_id=sel. If eop=1 (single-beat packet), stay in IDLE and set rr_ptr=(sel+1) mod N_IN.
  - LOCKED: i_axi[lock_id].rdy = out_free, all others 0; other requesters are ignored. When the beat with eop=1 is accepted, go to IDLE and set rr_ptr=(lock_id+1) mod N_IN. o_busy=1 only in this state.
- rdy dependencies: rdy never depends on the same source's sop. rdy does depend on the val of other sources through sel in IDLE; there is no combinational path from val to own rdy other than through sel.
- sop is not checked or enforced; the first accepted beat in IDLE starts a packet. err is passed through and does not end the lock; only eop ends it.
- Fairness: with all N_IN sources continuously requesting, grants rotate 0,1,...,N_IN-1,0,... one packet each.
- Throughput: one beat per cycle while o_axi.rdy=1, including back-to-back packets from different sources (no idle cycle at packet boundaries).
- Reset mid-packet: output is dropped immediately and the lock is cleared. Sources must restart their packets.
- A source deasserting val mid-packet (a gap) keeps the lock; the arbiter waits.

Test Plan:
- Reset: hold i_rst_n=0 with all val=1 -> every rdy=0, o_axi.val=0, o_busy=0. After release, the first packet is granted to source 0.
- Fairness: N_IN=4, all sources send endless 3-beat packets, o_axi.rdy=1 -> o_grant packet sequence is 0,1,2,3,0,1...; o_axi.val stays high every cycle; no interleaving; o_busy high for beats 1-2 of each packet.
- Single-beat packets: sources 1 and 3 each send sop=eop=1 beats continuously -> output alternates 1,3,1,3; o_busy never asserts.
- Backpressure: 4-beat packet from source 2 while o_axi.rdy toggles 1,0,0,1... -> o_axi fields stable while rdy=0; dat order preserved; mod on the eop beat matches the input (e.g. 5).
- Lock with gap: source 0 sends beat 1, drops val for 3 cycles, then sends eop; source 1 requests throughout -> source 1 is granted only after source 0's eop is accepted.
- Async reset mid-packet: assert i_rst_n=0 between beat 2 and 3 of a 4-beat packet -> o_axi.val=0 immediately; after release, rr_ptr=0 and the lock is cleared.
